// File: rtl/exu_flush_ctrl_pkg.sv
// Shared types and widths for the EXU flush sequencer.
`ifndef PC_SIZE
`define PC_SIZE 32
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef FLUSH_SRC_BRCH
`define FLUSH_SRC_BRCH 1'b0
`endif
`ifndef FLUSH_SRC_EXCP
`define FLUSH_SRC_EXCP 1'b1
`endif

package exu_flush_ctrl_pkg;

    localparam int unsigned PC_W = `PC_SIZE;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } flush_state_e;

endpackage

// File: rtl/exu_flush_ctrl.sv
// Arbitrates mispredict and exception flushes, holds one outstanding flush
// toward the IFU until acknowledged, and counts accepted flushes per source.
`ifndef PC_SIZE
`define PC_SIZE 32
`endif
`ifndef FLUSH_SRC_BRCH
`define FLUSH_SRC_BRCH 1'b0
`endif
`ifndef FLUSH_SRC_EXCP
`define FLUSH_SRC_EXCP 1'b1
`endif

module exu_flush_ctrl
    import exu_flush_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 brchmis_flush_req,
    input  logic [`PC_SIZE-1:0]  brchmis_flush_add_op1,
    input  logic [`PC_SIZE-1:0]  brchmis_flush_add_op2,
    output logic                 brchmis_flush_ack,
    input  logic                 excp_flush_req,
    input  logic [`PC_SIZE-1:0]  excp_flush_pc,
    output logic                 excp_flush_ack,
    output logic                 ifu_flush_req,
    output logic [`PC_SIZE-1:0]  ifu_flush_pc,
    output logic                 ifu_flush_src,
    input  logic                 ifu_flush_ack,
    output logic                 flush_kill,
    output logic                 flush_busy,
    output logic [CNT_W-1:0]     brchmis_cnt,
    output logic [CNT_W-1:0]     excp_cnt
);

    flush_state_e          r_state;
    flush_state_e          w_state_nxt;
    logic [`PC_SIZE-1:0]   r_pc;
    logic                  r_src;
    logic [CNT_W-1:0]      r_brch_cnt;
    logic [CNT_W-1:0]      r_excp_cnt;

    logic [`PC_SIZE-1:0]   w_brch_tgt;
    logic                  w_excp_acc;
    logic                  w_brch_acc;

    // Carry out of the target add is intentionally dropped.
    assign w_brch_tgt = brchmis_flush_add_op1 + brchmis_flush_add_op2;

    always_comb begin
        w_state_nxt = r_state;
        w_excp_acc  = 1'b0;
        w_brch_acc  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (excp_flush_req) begin
                    w_excp_acc  = 1'b1;
                    w_state_nxt = ST_REQ;
                end else if (brchmis_flush_req) begin
                    w_brch_acc  = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ifu_flush_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_src   <= `FLUSH_SRC_BRCH;
        end else begin
            r_state <= w_state_nxt;
            if (w_excp_acc) begin
                r_pc  <= excp_flush_pc;
                r_src <= `FLUSH_SRC_EXCP;
            end else if (w_brch_acc) begin
                r_pc  <= w_brch_tgt;
                r_src <= `FLUSH_SRC_BRCH;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_brch_cnt <= '0;
            r_excp_cnt <= '0;
        end else begin
            if (w_brch_acc && (r_brch_cnt != '1)) begin
                r_brch_cnt <= r_brch_cnt + CNT_W'(1);
            end
            if (w_excp_acc && (r_excp_cnt != '1)) begin
                r_excp_cnt <= r_excp_cnt + CNT_W'(1);
            end
        end
    end

    assign brchmis_flush_ack = w_brch_acc;
    assign excp_flush_ack    = w_excp_acc;
    assign flush_kill        = w_brch_acc | w_excp_acc;
    assign ifu_flush_req     = (r_state == ST_REQ);
    assign flush_busy        = (r_state != ST_IDLE);
    assign ifu_flush_pc      = r_pc;
    assign ifu_flush_src     = r_src;
    assign brchmis_cnt       = r_brch_cnt;
    assign excp_cnt          = r_excp_cnt;

endmodule

// File: tb/tb_exu_flush_ctrl.sv
// Scoreboard bench for exu_flush_ctrl with 2-bit counters to reach saturation.
`timescale 1ns/1ps

module tb_exu_flush_ctrl;

    localparam int unsigned CNT_W = 2;

    logic              clk;
    logic              rst_n;
    logic              brchmis_flush_req;
    logic [31:0]       brchmis_flush_add_op1;
    logic [31:0]       brchmis_flush_add_op2;
    logic              brchmis_flush_ack;
    logic              excp_flush_req;
    logic [31:0]       excp_flush_pc;
    logic              excp_flush_ack;
    logic              ifu_flush_req;
    logic [31:0]       ifu_flush_pc;
    logic              ifu_flush_src;
    logic              ifu_flush_ack;
    logic              flush_kill;
    logic              flush_busy;
    logic [CNT_W-1:0]  brchmis_cnt;
    logic [CNT_W-1:0]  excp_cnt;

    int unsigned n_chk;
    int unsigned n_fail;
    logic [32:0] exp_q[$];
    int unsigned m_brch;
    int unsigned m_excp;

    exu_flush_ctrl #(.CNT_W(CNT_W)) u_dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .brchmis_flush_req     (brchmis_flush_req),
        .brchmis_flush_add_op1 (brchmis_flush_add_op1),
        .brchmis_flush_add_op2 (brchmis_flush_add_op2),
        .brchmis_flush_ack     (brchmis_flush_ack),
        .excp_flush_req        (excp_flush_req),
        .excp_flush_pc         (excp_flush_pc),
        .excp_flush_ack        (excp_flush_ack),
        .ifu_flush_req         (ifu_flush_req),
        .ifu_flush_pc          (ifu_flush_pc),
        .ifu_flush_src         (ifu_flush_src),
        .ifu_flush_ack         (ifu_flush_ack),
        .flush_kill            (flush_kill),
        .flush_busy            (flush_busy),
        .brchmis_cnt           (brchmis_cnt),
        .excp_cnt              (excp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Called at the negedge of a capture cycle; returns at posedge+1 of the first REQ cycle.
    task automatic capture_check(input string tag, input bit exc, input logic [31:0] pc);
        chk({tag, ".excp_ack"}, 64'(excp_flush_ack), 64'(exc));
        chk({tag, ".brch_ack"}, 64'(brchmis_flush_ack), 64'(!exc));
        chk({tag, ".kill"}, 64'(flush_kill), 64'd1);
        exp_q.push_back({exc, pc});
        if (exc) begin
            if (m_excp < 3) m_excp++;
        end else begin
            if (m_brch < 3) m_brch++;
        end
        @(posedge clk); #1;
        if (exc) excp_flush_req = 1'b0;
        else     brchmis_flush_req = 1'b0;
        chk({tag, ".brch_cnt"}, 64'(brchmis_cnt), 64'(m_brch));
        chk({tag, ".excp_cnt"}, 64'(excp_cnt), 64'(m_excp));
    endtask

    // Starts at posedge+1 of the first REQ cycle; holds IFU ack low for 'hold' cycles.
    task automatic serve(input string tag, input int unsigned hold);
        logic [32:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, ".queue_empty"}, 64'd1, 64'd0);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        for (int unsigned c = 0; c <= hold; c++) begin
            if (c == hold) ifu_flush_ack = 1'b1;
            @(negedge clk);
            chk({tag, ".ifu_req"}, 64'(ifu_flush_req), 64'd1);
            chk({tag, ".ifu_pc"}, 64'(ifu_flush_pc), 64'(e[31:0]));
            chk({tag, ".ifu_src"}, 64'(ifu_flush_src), 64'(e[32]));
            chk({tag, ".no_ack"}, 64'({excp_flush_ack, brchmis_flush_ack, flush_kill}), 64'd0);
            @(posedge clk); #1;
        end
        ifu_flush_ack = 1'b0;
        @(negedge clk);
        chk({tag, ".idle_busy"}, 64'(flush_busy), 64'd0);
        chk({tag, ".idle_req"}, 64'(ifu_flush_req), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".outs"}, 64'({ifu_flush_req, ifu_flush_src, flush_kill, flush_busy,
                                 brchmis_flush_ack, excp_flush_ack}), 64'd0);
        chk({tag, ".pc"}, 64'(ifu_flush_pc), 64'd0);
        chk({tag, ".cnts"}, 64'({brchmis_cnt, excp_cnt}), 64'd0);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; m_brch = 0; m_excp = 0;
        rst_n = 1'b0;
        brchmis_flush_req = 1'b0; brchmis_flush_add_op1 = '0; brchmis_flush_add_op2 = '0;
        excp_flush_req = 1'b0; excp_flush_pc = '0; ifu_flush_ack = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Mispredict alone, IFU ack held off for 3 cycles.
        @(posedge clk); #1;
        brchmis_flush_req = 1'b1;
        brchmis_flush_add_op1 = 32'h0000_1000; brchmis_flush_add_op2 = 32'h0000_0040;
        @(negedge clk);
        capture_check("brch1", 1'b0, 32'h0000_1040);
        serve("brch1", 3);

        // Simultaneous: exception wins, branch captured once IDLE again.
        @(posedge clk); #1;
        excp_flush_req = 1'b1; excp_flush_pc = 32'h0000_0200;
        brchmis_flush_req = 1'b1;
        brchmis_flush_add_op1 = 32'h0000_3000; brchmis_flush_add_op2 = 32'h0000_0010;
        @(negedge clk);
        capture_check("simul_e", 1'b1, 32'h0000_0200);
        serve("simul_e", 0);
        capture_check("simul_b", 1'b0, 32'h0000_3010);
        serve("simul_b", 0);

        // Target wraps modulo 2^32.
        @(posedge clk); #1;
        brchmis_flush_req = 1'b1;
        brchmis_flush_add_op1 = 32'hFFFF_FFFC; brchmis_flush_add_op2 = 32'h0000_0008;
        @(negedge clk);
        capture_check("wrap", 1'b0, 32'h0000_0004);
        serve("wrap", 1);

        // New mispredict arrives while REQ is outstanding: must wait.
        @(posedge clk); #1;
        brchmis_flush_req = 1'b1;
        brchmis_flush_add_op1 = 32'h0000_8000; brchmis_flush_add_op2 = 32'h0000_0100;
        @(negedge clk);
        capture_check("inreq1", 1'b0, 32'h0000_8100);
        brchmis_flush_req = 1'b1;
        brchmis_flush_add_op1 = 32'h0000_A000; brchmis_flush_add_op2 = 32'h0000_0004;
        serve("inreq1", 2);
        capture_check("inreq2", 1'b0, 32'h0000_A004);
        serve("inreq2", 0);

        // IFU ack while IDLE has no effect.
        @(posedge clk); #1;
        ifu_flush_ack = 1'b1;
        @(posedge clk); #1;
        ifu_flush_ack = 1'b0;
        @(negedge clk);
        chk("idle_ack.busy", 64'(flush_busy), 64'd0);
        chk("idle_ack.req", 64'(ifu_flush_req), 64'd0);

        // Asynchronous reset while a flush is outstanding.
        @(posedge clk); #1;
        excp_flush_req = 1'b1; excp_flush_pc = 32'h0000_0BC0;
        @(negedge clk);
        capture_check("rst_mid", 1'b1, 32'h0000_0BC0);
        void'(exp_q.pop_front());
        @(negedge clk);
        chk("rst_mid.req_before", 64'(ifu_flush_req), 64'd1);
        #1 rst_n = 1'b0;
        #1 check_all_zero("rst_mid.async");
        m_brch = 0; m_excp = 0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid.no_replay", 64'({ifu_flush_req, flush_busy}), 64'd0);
        end

        // Saturation of the 2-bit mispredict counter: 1,2,3,3,3.
        for (int unsigned k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            brchmis_flush_req = 1'b1;
            brchmis_flush_add_op1 = 32'h0000_4000 + 32'(k * 16); brchmis_flush_add_op2 = 32'h0000_0020;
            @(negedge clk);
            capture_check("sat", 1'b0, 32'h0000_4020 + 32'(k * 16));
            serve("sat", 0);
        end
        chk("sat.final", 64'(brchmis_cnt), 64'd3);
        chk("sat.queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/exu_flush_ctrl.md
# exu_flush_ctrl

Sequences all pipeline-flush requests from the EXU toward the IFU. It arbitrates between the branch-mispredict flush source (branch solve) and the exception/trap flush source, and computes the mispredict target (op1+op2). It captures the winning target into a register and holds a single outstanding flush request to the IFU until that request is acknowledged. It also kills younger in-flight instructions and keeps saturating per-source flush counters for performance monitoring.

## Interface
Parameters:
- CNT_W, 16, width of each saturating flush counter

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low
- brchmis_flush_req  in  1  mispredict flush request, held until brchmis_flush_ack
- brchmis_flush_add_op1  in  `PC_SIZE  mispredict target operand 1 (branch PC)
- brchmis_flush_add_op2  in  `PC_SIZE  mispredict target operand 2 (offset)
- brchmis_flush_ack  out  1  mispredict request accepted (captured) this cycle
- excp_flush_req  in  1  exception/trap flush request, held until excp_flush_ack
- excp_flush_pc  in  `PC_SIZE  trap target PC
- excp_flush_ack  out  1  exception request accepted this cycle
- ifu_flush_req  out  1  registered flush request to IFU
- ifu_flush_pc  out  `PC_SIZE  registered flush target
- ifu_flush_src  out  1  0 = mispredict, 1 = exception (`FLUSH_SRC_* encoding)
- ifu_flush_ack  in  1  IFU accepts flush
- flush_kill  out  1  one-cycle pulse: squash all instructions younger than the flusher
- flush_busy  out  1  a flush is outstanding (state != IDLE)
- brchmis_cnt  out  CNT_W  saturating count of accepted mispredict flushes
- excp_cnt  out  CNT_W  saturating count of accepted exception flushes

## Operation
- FSM states: IDLE, REQ.
- IDLE:
  - If excp_flush_req is set, capture excp_flush_pc and src=1, assert excp_flush_ack, and go to REQ.
  - Otherwise, if brchmis_flush_req is set, capture op1+op2 (modulo 2^`PC_SIZE, carry dropped) and src=0, assert brchmis_flush_ack, and go to REQ.
  - Exception always wins a simultaneous request. The losing branch request stays pending with no ack.
- Capture cycle: flush_kill=1 (combinational, same cycle as the source ack). The relevant counter increments and saturates at all-ones.
- REQ:
  - ifu_flush_req=1 with registered pc/src, held stable until ifu_flush_ack=1.
  - On ifu_flush_ack, go to IDLE.
  - No source acks are given in REQ, including the ack cycle. New requests wait.
- Sources must hold their request and operands stable until acked. The block does not re-check operands after capture.
- Source acks are combinational from req and state. There is no comb path from ifu_flush_ack to any source ack.

## Timing
- Reset values:
  - state=IDLE
  - ifu_flush_req=0, ifu_flush_pc=0, ifu_flush_src=0
  - flush_kill=0, flush_busy=0
  - both acks=0, both counters=0
- Reset mid-REQ drops the outstanding flush immediately. No request is re-issued after reset.
- Latency: source req in cycle N (IDLE) → source ack and flush_kill in N → ifu_flush_req from N+1.
- IFU ack at N+1 gives IDLE at N+2. The earliest next capture is N+2, so back-to-back flushes are spaced at least 2 cycles apart.
- ifu_flush_ack while IDLE is ignored.
- Counter at all-ones plus another accept stays at all-ones.

## Structure
- Add `FLUSH_SRC_BRCH (1'b0) and `FLUSH_SRC_EXCP (1'b1) to defines.v alongside `PC_SIZE/`XLEN.
- Single flat module with no sub-modules. The target adder, FSM, capture registers and the two counters are inline.
- The branch-solve block connects brchmis_flush_* directly. Its commit-ready then releases in the capture cycle.

## Test plan
- Mispredict alone: op1=0x0000_1000, op2=0x0000_0040 at cycle N → brchmis_flush_ack=1 and flush_kill=1 at N. At N+1, ifu_flush_req=1, pc=0x0000_1040, src=0. Hold IFU ack low 3 cycles: req and pc stay stable. Ack at N+4 → IDLE at N+5, brchmis_cnt=1.
- Simultaneous: excp_flush_pc=0x0000_0200 and mispredict both at N → only excp_flush_ack at N. IFU sees pc=0x0000_0200, src=1. Ack at N+1. At N+2 the branch is captured and brchmis_flush_ack=1. Final counts excp_cnt=1, brchmis_cnt=1.
- Wrap: op1=0xFFFF_FFFC, op2=0x0000_0008 → ifu_flush_pc=0x0000_0004.
- Request during REQ: a mispredict arriving while REQ is outstanding gets no ack until IDLE. No second flush_kill fires in that window.
- Reset mid-REQ: assert rst_n=0 while ifu_flush_req=1 → all outputs 0 immediately (async). After release, state is IDLE and no request is replayed.
- Saturation with CNT_W=2: five accepted mispredicts → brchmis_cnt sequence 1,2,3,3,3.
